// File: rtl/bloco_pkg.sv
// Shared definitions for the bloco_controle FSM: state encoding, mux selects, ULA op codes.
// The CLEAR state is reachable only when CTRL_CLEAR_EN is defined.
package bloco_pkg;

    localparam int unsigned STATE_W = 3;
    localparam int unsigned SEL_W   = 2;

    localparam logic OP_SOMA = 1'b0;
    localparam logic OP_MULT = 1'b1;

    localparam logic [SEL_W-1:0] SEL0_ZERO = 2'b00;
    localparam logic [SEL_W-1:0] SEL0_A    = 2'b01;
    localparam logic [SEL_W-1:0] SEL0_B    = 2'b10;
    localparam logic [SEL_W-1:0] SEL0_C    = 2'b11;

    localparam logic [SEL_W-1:0] SEL1_MUX0 = 2'b00;
    localparam logic [SEL_W-1:0] SEL1_X    = 2'b01;
    localparam logic [SEL_W-1:0] SEL1_S    = 2'b10;
    localparam logic [SEL_W-1:0] SEL1_H    = 2'b11;

    localparam logic [SEL_W-1:0] SEL2_X    = 2'b00;
    localparam logic [SEL_W-1:0] SEL2_MUX0 = 2'b01;
    localparam logic [SEL_W-1:0] SEL2_S    = 2'b10;
    localparam logic [SEL_W-1:0] SEL2_H    = 2'b11;

    typedef enum logic [STATE_W-1:0] {
        IDLE   = 3'd0,
        LOAD_X = 3'd1,
        MUL_A  = 3'd2,
        MUL_B  = 3'd3,
        ADD_H  = 3'd4,
        ADD_C  = 3'd5,
        DONE   = 3'd6,
        CLEAR  = 3'd7
    } estado_t;

    typedef struct packed {
        logic             lX;
        logic             lH;
        logic             lS;
        logic [SEL_W-1:0] m0;
        logic [SEL_W-1:0] m1;
        logic [SEL_W-1:0] m2;
        logic             h;
        logic             busy;
        logic             done;
    } ctrl_t;

    localparam ctrl_t CTRL_RESET = '{
        lX: 1'b0, lH: 1'b0, lS: 1'b0,
        m0: SEL0_ZERO, m1: SEL1_MUX0, m2: SEL2_X,
        h: OP_SOMA, busy: 1'b0, done: 1'b0
    };

    // Moore output decode: every field not set by a state keeps its idle value
    function automatic ctrl_t decodifica(input estado_t estado);
        ctrl_t c;
        c = CTRL_RESET;
        c.busy = (estado != IDLE) && (estado != DONE);
        case (estado)
            CLEAR: begin
                c.m2 = SEL2_MUX0;
                c.lS = 1'b1;
                c.lH = 1'b1;
            end
            LOAD_X: c.lX = 1'b1;
            MUL_A: begin
                c.m0 = SEL0_A;
                c.h  = OP_MULT;
                c.lH = 1'b1;
            end
            MUL_B: begin
                c.m0 = SEL0_B;
                c.h  = OP_MULT;
                c.lS = 1'b1;
            end
            ADD_H: begin
                c.m1 = SEL1_H;
                c.m2 = SEL2_S;
                c.lS = 1'b1;
            end
            ADD_C: begin
                c.m0 = SEL0_C;
                c.m2 = SEL2_S;
                c.lS = 1'b1;
            end
            DONE:    c.done = 1'b1;
            default: c = CTRL_RESET;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/bloco_controle_if.sv
// Request handshake plus control lines between bloco_controle and its neighbours.
interface bloco_controle_if;
    import bloco_pkg::*;

    logic             start;
    logic             abort;
    logic             LX;
    logic             LH;
    logic             LS;
    logic [SEL_W-1:0] M0;
    logic [SEL_W-1:0] M1;
    logic [SEL_W-1:0] M2;
    logic             H;
    logic             busy;
    logic             done;

    modport master (
        output start, abort,
        input  LX, LH, LS, M0, M1, M2, H, busy, done
    );

    modport slave (
        input  start, abort,
        output LX, LH, LS, M0, M1, M2, H, busy, done
    );

endinterface

// File: rtl/bloco_controle.sv
// Moore controller sequencing resultado = A*K + B*K + C on the operative block.
// Optional macro CTRL_CLEAR_EN inserts a CLEAR state that zeroes S and H before LOAD_X.
module bloco_controle
    import bloco_pkg::*;
(
    input logic             clk,
    input logic             rst_n,
    bloco_controle_if.slave ctrl
);

    estado_t estado;
    ctrl_t   saida;

    // abort outranks start and every sequencing transition
    function automatic estado_t proximoEstado(input estado_t atual, input logic start,
                                              input logic abort);
        estado_t prox;
        prox = IDLE;
        if (!abort) begin
            case (atual)
`ifdef CTRL_CLEAR_EN
                IDLE:   prox = start ? CLEAR : IDLE;
                CLEAR:  prox = LOAD_X;
`else
                IDLE:   prox = start ? LOAD_X : IDLE;
`endif
                LOAD_X: prox = MUL_A;
                MUL_A:  prox = MUL_B;
                MUL_B:  prox = ADD_H;
                ADD_H:  prox = ADD_C;
                ADD_C:  prox = DONE;
                DONE:   prox = IDLE;
                default: prox = IDLE;
            endcase
        end
        return prox;
    endfunction

    // Outputs are registered alongside the state so they always equal decodifica(estado)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado <= IDLE;
            saida  <= CTRL_RESET;
        end else begin
            estado <= proximoEstado(estado, ctrl.start, ctrl.abort);
            saida  <= decodifica(proximoEstado(estado, ctrl.start, ctrl.abort));
        end
    end

    assign ctrl.LX   = saida.lX;
    assign ctrl.LH   = saida.lH;
    assign ctrl.LS   = saida.lS;
    assign ctrl.M0   = saida.m0;
    assign ctrl.M1   = saida.m1;
    assign ctrl.M2   = saida.m2;
    assign ctrl.H    = saida.h;
    assign ctrl.busy = saida.busy;
    assign ctrl.done = saida.done;

endmodule

// File: tb/tb_bloco_controle.sv
// Scoreboard bench for bloco_controle driving a behavioural model of the 16-bit operative block.
// Latency and busy expectations adapt when CTRL_CLEAR_EN is defined.
module tb_bloco_controle;
    import bloco_pkg::*;

`ifdef CTRL_CLEAR_EN
    localparam int LAT = 7;
`else
    localparam int LAT = 6;
`endif

    logic clk;
    logic rst_n;
    bloco_controle_if bus();

    bloco_controle dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ctrl  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural operative block
    logic [15:0] A, B, C, K, X, S, Hr;
    logic [15:0] mux0, opA, opB, ula;
    logic        preload;

    always_comb begin
        case (bus.M0)
            2'b00:   mux0 = 16'h0;
            2'b01:   mux0 = A;
            2'b10:   mux0 = B;
            default: mux0 = C;
        endcase
        case (bus.M1)
            2'b00:   opB = mux0;
            2'b01:   opB = X;
            2'b10:   opB = S;
            default: opB = Hr;
        endcase
        case (bus.M2)
            2'b00:   opA = X;
            2'b01:   opA = mux0;
            2'b10:   opA = S;
            default: opA = Hr;
        endcase
        ula = (bus.H == OP_MULT) ? 16'(opA * opB) : 16'(opA + opB);
    end

    always @(posedge clk) begin
        if (bus.LX) X <= K;
        if (bus.LH) Hr <= ula;
        if (preload) S <= 16'h1234;
        else if (bus.LS) S <= ula;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [15:0] res;
        int          edgeNo;
    } exp_t;
    exp_t q[$];

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding request
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.done === 1'b1) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: done=1 with no pending request at cycle %0d", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("resultado", int'(S), int'(e.res));
                chk("done_edge", cyc, e.edgeNo);
            end
        end
    end

    task automatic runOne(input logic [15:0] a, b, c, k, res);
        int busyCnt;
        bit seen;
        busyCnt = 0;
        seen    = 1'b0;
        @(posedge clk); #1;
        A = a; B = b; C = c; K = k;
        bus.start = 1'b1;
        preload   = 1'b1;
        q.push_back('{res, cyc + LAT});
        @(posedge clk); #1;
        bus.start = 1'b0;
        preload   = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
`ifdef CTRL_CLEAR_EN
            if (i == 1) chk("clear_S_zero", int'(S), 0);
`endif
            if (bus.busy) busyCnt++;
            if (bus.done) seen = 1'b1;
        end
        chk("done_seen", int'(seen), 1);
        chk("busy_cycles", busyCnt, LAT - 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        preload   = 1'b0;
        A = '0; B = '0; C = '0; K = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", int'({bus.LX, bus.LH, bus.LS, bus.M0, bus.M1, bus.M2,
                                   bus.H, bus.busy, bus.done}), 0);
        @(negedge clk);
        rst_n = 1'b1;

        runOne(16'd3, 16'd4, 16'd5, 16'd2, 16'd19);
        runOne(16'h8000, 16'h0001, 16'hFFFF, 16'd2, 16'h0001);

        // Abort while in ADD_H: no done, back to IDLE
        @(posedge clk); #1;
        A = 16'd7; B = 16'd7; C = 16'd7; K = 16'd7;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (LAT - 3) @(posedge clk);
        #1;
        chk("pre_abort_add_h", int'({bus.M1, bus.M2, bus.LS}), int'({SEL1_H, SEL2_S, 1'b1}));
        bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.abort = 1'b0;
        chk("abort_busy", int'(bus.busy), 0);
        chk("abort_done", int'(bus.done), 0);
        repeat (8) @(posedge clk);
        runOne(16'd1, 16'd1, 16'd1, 16'd1, 16'd3);

        // Back-to-back: start held for 20 cycles gives three runs
        @(posedge clk); #1;
        A = 16'd1; B = 16'd2; C = 16'd3; K = 16'd4;
        bus.start = 1'b1;
        e0 = cyc;
        for (int r = 0; r < 3; r++) q.push_back('{16'd15, e0 + LAT + r * (LAT + 1)});
        repeat (20) @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (2 * LAT) @(posedge clk);
        chk("b2b_all_done", q.size(), 0);

        // Asynchronous reset in MUL_B
        @(posedge clk); #1;
        A = 16'd9; B = 16'd9; C = 16'd9; K = 16'd9;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (LAT - 4) @(posedge clk);
        #2;
        chk("pre_reset_mul_b", int'({bus.M0, bus.H, bus.LS}), int'({SEL0_B, OP_MULT, 1'b1}));
        rst_n = 1'b0;
        #1;
        chk("midrun_reset_outputs", int'({bus.LX, bus.LH, bus.LS, bus.M0, bus.M1, bus.M2,
                                          bus.H, bus.busy, bus.done}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("post_reset_idle", int'({bus.busy, bus.done}), 0);

        runOne(16'd10, 16'd20, 16'd30, 16'd3, 16'd120);

        repeat (3) @(posedge clk);
        chk("queue_empty", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
